// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dmem arbiter.
package dmem_arb_pkg;

  localparam int DMEM_W = 16;   // dmem data/address width
  localparam int DMEM_R = 5;    // low address bits decoded by dmem

  localparam logic PORT0 = 1'b0; // CPU load/store unit
  localparam logic PORT1 = 1'b1; // debug / program loader

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin chooser: a lone request wins outright,
// a tie goes to the port that was not served last.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       winner_o
);

  // Tie-break against the most recently served port.
  always_comb begin
    valid_o  = |req_i;
    winner_o = PORT0;
    if (req_i == 2'b11) begin
      winner_o = ~last_i;
    end else if (req_i[1]) begin
      winner_o = PORT1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port dmem.
// Port 0 = CPU load/store unit, port 1 = debug/program loader.
// Each access takes IDLE -> ACCESS -> DONE (one access per three cycles).
// Optional build macro DMEM_ARB_LOCK_EN adds per-port lock inputs that let
// the winning port keep exclusive ownership across consecutive accesses.
//
// state  | meaning
// IDLE   | arbitrate; winning command captured on the edge
// ACCESS | command on dmem, grant pulse, read data captured on the edge
// DONE   | read-valid pulse for reads, dmem write disabled
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N = DMEM_W
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
`ifdef DMEM_ARB_LOCK_EN
  input  logic         p0_lock_i,
  input  logic         p1_lock_i,
`endif
  input  logic         p0_req_i,
  input  logic         p0_we_i,
  input  logic [N-1:0] p0_addr_i,
  input  logic [N-1:0] p0_wdata_i,
  output logic         p0_gnt_o,
  output logic         p0_rvalid_o,
  output logic [N-1:0] p0_rdata_o,
  input  logic         p1_req_i,
  input  logic         p1_we_i,
  input  logic [N-1:0] p1_addr_i,
  input  logic [N-1:0] p1_wdata_i,
  output logic         p1_gnt_o,
  output logic         p1_rvalid_o,
  output logic [N-1:0] p1_rdata_o,
  output logic [N-1:0] dmem_addr_o,
  output logic         dmem_we_o,
  output logic [N-1:0] dmem_writedata_o,
  input  logic [N-1:0] dmem_readdata_i
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       cmd_port_q, cmd_port_d;
  logic       cmd_we_q, cmd_we_d;
  logic [N-1:0] cmd_addr_q, cmd_addr_d;
  logic [N-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [N-1:0] rdata0_q, rdata0_d;
  logic [N-1:0] rdata1_q, rdata1_d;

  logic [1:0] req;
  logic [1:0] pick_req;
  logic       pick_valid;
  logic       pick_winner;

  assign req = {p1_req_i, p0_req_i};

`ifdef DMEM_ARB_LOCK_EN
  logic       locked_q, locked_d;
  logic       owner_q, owner_d;
  logic [1:0] lock;
  logic       lock_hold;

  assign lock = {p1_lock_i, p0_lock_i};

  // A lock survives only while its owner keeps lock high; once it drops,
  // round-robin resumes in the very same IDLE cycle.
  always_comb begin
    lock_hold = locked_q & lock[owner_q];
    pick_req  = req;
    if (lock_hold) begin
      pick_req = req & ((owner_q == PORT1) ? 2'b10 : 2'b01);
    end
  end

  // Lock ownership is set or released only while arbitrating in IDLE.
  always_comb begin
    locked_d = locked_q;
    owner_d  = owner_q;
    if (state_q == IDLE) begin
      locked_d = lock_hold;
      if (pick_valid && lock[pick_winner]) begin
        locked_d = 1'b1;
        owner_d  = pick_winner;
      end
    end
  end

  // Lock state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      locked_q <= 1'b0;
      owner_q  <= PORT0;
    end else begin
      locked_q <= locked_d;
      owner_q  <= owner_d;
    end
  end
`else
  assign pick_req = req;
`endif

  rr_pick2 u_pick (
    .req_i    (pick_req),
    .last_i   (last_q),
    .valid_o  (pick_valid),
    .winner_o (pick_winner)
  );

  // Next state, command capture and read-data capture.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cmd_port_d  = cmd_port_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = ACCESS;
          cmd_port_d = pick_winner;
          if (pick_winner == PORT1) begin
            cmd_we_d    = p1_we_i;
            cmd_addr_d  = p1_addr_i;
            cmd_wdata_d = p1_wdata_i;
          end else begin
            cmd_we_d    = p0_we_i;
            cmd_addr_d  = p0_addr_i;
            cmd_wdata_d = p0_wdata_i;
          end
        end
      end
      ACCESS: begin
        state_d = DONE;
        last_d  = cmd_port_q;
        if (!cmd_we_q) begin
          if (cmd_port_q == PORT1) rdata1_d = dmem_readdata_i;
          else                     rdata0_d = dmem_readdata_i;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and command registers; last resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      last_q      <= PORT1;
      cmd_port_q  <= PORT0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cmd_port_q  <= cmd_port_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // The command registers only change on an IDLE capture, so they also
  // give the required hold of dmem address/data outside ACCESS.
  assign dmem_addr_o      = cmd_addr_q;
  assign dmem_writedata_o = cmd_wdata_q;
  assign dmem_we_o        = (state_q == ACCESS) && cmd_we_q;

  assign p0_gnt_o    = (state_q == ACCESS) && (cmd_port_q == PORT0);
  assign p1_gnt_o    = (state_q == ACCESS) && (cmd_port_q == PORT1);
  assign p0_rvalid_o = (state_q == DONE) && !cmd_we_q && (cmd_port_q == PORT0);
  assign p1_rvalid_o = (state_q == DONE) && !cmd_we_q && (cmd_port_q == PORT1);
  assign p0_rdata_o  = rdata0_q;
  assign p1_rdata_o  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: cycle table plus hand sequences for reset abort
// and (when DMEM_ARB_LOCK_EN is defined) port locking.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [15:0] p0_rdata, p1_rdata;
  logic [15:0] dmem_addr, dmem_writedata, dmem_readdata;
  logic        dmem_we;
`ifdef DMEM_ARB_LOCK_EN
  logic        p0_lock, p1_lock;
`endif

  logic [15:0] mem [0:(1<<DMEM_R)-1];

  int checks = 0;
  int failures = 0;

  dmem_arbiter #(.N(16)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
`ifdef DMEM_ARB_LOCK_EN
    .p0_lock_i        (p0_lock),
    .p1_lock_i        (p1_lock),
`endif
    .p0_req_i         (p0_req),
    .p0_we_i          (p0_we),
    .p0_addr_i        (p0_addr),
    .p0_wdata_i       (p0_wdata),
    .p0_gnt_o         (p0_gnt),
    .p0_rvalid_o      (p0_rvalid),
    .p0_rdata_o       (p0_rdata),
    .p1_req_i         (p1_req),
    .p1_we_i          (p1_we),
    .p1_addr_i        (p1_addr),
    .p1_wdata_i       (p1_wdata),
    .p1_gnt_o         (p1_gnt),
    .p1_rvalid_o      (p1_rvalid),
    .p1_rdata_o       (p1_rdata),
    .dmem_addr_o      (dmem_addr),
    .dmem_we_o        (dmem_we),
    .dmem_writedata_o (dmem_writedata),
    .dmem_readdata_i  (dmem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem model: combinational read, write on the rising edge.
  assign dmem_readdata = mem[dmem_addr[DMEM_R-1:0]];
  always @(posedge clk) begin
    if (dmem_we) mem[dmem_addr[DMEM_R-1:0]] <= dmem_writedata;
  end

  typedef struct {
    logic r0, w0; logic [15:0] a0, d0;
    logic r1, w1; logic [15:0] a1, d1;
    logic g0, v0; logic [15:0] rd0;
    logic g1, v1; logic [15:0] rd1;
    logic we; logic [15:0] da, dd;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(
    logic r0, logic w0, logic [15:0] a0, logic [15:0] d0,
    logic r1, logic w1, logic [15:0] a1, logic [15:0] d1,
    logic g0, logic v0, logic [15:0] rd0,
    logic g1, logic v1, logic [15:0] rd1,
    logic we, logic [15:0] da, logic [15:0] dd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.v0 = v0; v.rd0 = rd0;
    v.g1 = g1; v.v1 = v1; v.rd1 = rd1;
    v.we = we; v.da = da; v.dd = dd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
`ifdef DMEM_ARB_LOCK_EN
    p0_lock = 0; p1_lock = 0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic found;
    idle_inputs();
    for (int i = 0; i < (1 << DMEM_R); i++) mem[i] = 16'hA500 + 16'(i);
    do_reset();

    @(negedge clk);
    chk("rst_p0_gnt", {31'b0, p0_gnt}, 0);
    chk("rst_p1_gnt", {31'b0, p1_gnt}, 0);
    chk("rst_rvalid", {30'b0, p1_rvalid, p0_rvalid}, 0);
    chk("rst_rdata", {p1_rdata, p0_rdata}, 0);
    chk("rst_dmem_we", {31'b0, dmem_we}, 0);
    chk("rst_dmem_addr_wd", {dmem_addr, dmem_writedata}, 0);
    @(posedge clk); #1;

    //               p0 req/we/addr/wdata         p1 req/we/addr/wdata         g0 v0 rd0        g1 v1 rd1        we addr      wdata
    tbl.push_back(mk(1,1,16'h0000,16'hFFFF, 0,0,16'h0000,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 0,16'h0000,16'h0000)); // 0
    tbl.push_back(mk(1,1,16'h0000,16'hFFFF, 0,0,16'h0000,16'h0000, 1,0,16'h0000, 0,0,16'h0000, 1,16'h0000,16'hFFFF)); // 1
    tbl.push_back(mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 0,16'h0000,16'hFFFF)); // 2
    tbl.push_back(mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 0,16'h0000,16'hFFFF)); // 3
    tbl.push_back(mk(0,0,16'h0000,16'h0000, 1,0,16'h0000,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 0,16'h0000,16'hFFFF)); // 4
    tbl.push_back(mk(0,0,16'h0000,16'h0000, 1,0,16'h0000,16'h0000, 0,0,16'h0000, 1,0,16'h0000, 0,16'h0000,16'h0000)); // 5
    tbl.push_back(mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,16'h0000, 0,1,16'hFFFF, 0,16'h0000,16'h0000)); // 6
    tbl.push_back(mk(1,1,16'h0001,16'h00FF, 1,1,16'h0002,16'h0000, 0,0,16'h0000, 0,0,16'hFFFF, 0,16'h0000,16'h0000)); // 7
    tbl.push_back(mk(1,1,16'h0001,16'h00FF, 1,1,16'h0002,16'h0000, 1,0,16'h0000, 0,0,16'hFFFF, 1,16'h0001,16'h00FF)); // 8
    tbl.push_back(mk(0,0,16'h0000,16'h0000, 1,1,16'h0002,16'h0000, 0,0,16'h0000, 0,0,16'hFFFF, 0,16'h0001,16'h00FF)); // 9
    tbl.push_back(mk(1,1,16'h0001,16'h00FF, 1,1,16'h0002,16'h0000, 0,0,16'h0000, 0,0,16'hFFFF, 0,16'h0001,16'h00FF)); // 10
    tbl.push_back(mk(1,1,16'h0001,16'h00FF, 1,1,16'h0002,16'h0000, 0,0,16'h0000, 1,0,16'hFFFF, 1,16'h0002,16'h0000)); // 11
    tbl.push_back(mk(1,1,16'h0001,16'h00FF, 0,0,16'h0000,16'h0000, 0,0,16'h0000, 0,0,16'hFFFF, 0,16'h0002,16'h0000)); // 12
    tbl.push_back(mk(1,1,16'h0001,16'h00FF, 0,0,16'h0000,16'h0000, 0,0,16'h0000, 0,0,16'hFFFF, 0,16'h0002,16'h0000)); // 13
    tbl.push_back(mk(1,1,16'h0001,16'h00FF, 0,0,16'h0000,16'h0000, 1,0,16'h0000, 0,0,16'hFFFF, 1,16'h0001,16'h00FF)); // 14
    tbl.push_back(mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,16'h0000, 0,0,16'hFFFF, 0,16'h0001,16'h00FF)); // 15
    tbl.push_back(mk(1,0,16'h0001,16'h0000, 0,0,16'h0000,16'h0000, 0,0,16'h0000, 0,0,16'hFFFF, 0,16'h0001,16'h00FF)); // 16
    tbl.push_back(mk(1,0,16'h0001,16'h0000, 1,0,16'h0002,16'h0000, 1,0,16'h0000, 0,0,16'hFFFF, 0,16'h0001,16'h0000)); // 17
    tbl.push_back(mk(1,0,16'h0001,16'h0000, 1,0,16'h0002,16'h0000, 0,1,16'h00FF, 0,0,16'hFFFF, 0,16'h0001,16'h0000)); // 18
    tbl.push_back(mk(1,0,16'h0001,16'h0000, 1,0,16'h0002,16'h0000, 0,0,16'h00FF, 0,0,16'hFFFF, 0,16'h0001,16'h0000)); // 19
    tbl.push_back(mk(1,0,16'h0001,16'h0000, 1,0,16'h0002,16'h0000, 0,0,16'h00FF, 1,0,16'hFFFF, 0,16'h0002,16'h0000)); // 20
    tbl.push_back(mk(1,0,16'h0001,16'h0000, 0,0,16'h0000,16'h0000, 0,0,16'h00FF, 0,1,16'h0000, 0,16'h0002,16'h0000)); // 21
    tbl.push_back(mk(1,0,16'h0001,16'h0000, 0,0,16'h0000,16'h0000, 0,0,16'h00FF, 0,0,16'h0000, 0,16'h0002,16'h0000)); // 22
    tbl.push_back(mk(1,0,16'h0001,16'h0000, 0,0,16'h0000,16'h0000, 1,0,16'h00FF, 0,0,16'h0000, 0,16'h0001,16'h0000)); // 23
    tbl.push_back(mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,1,16'h00FF, 0,0,16'h0000, 0,16'h0001,16'h0000)); // 24

    foreach (tbl[i]) begin
      p0_req = tbl[i].r0; p0_we = tbl[i].w0; p0_addr = tbl[i].a0; p0_wdata = tbl[i].d0;
      p1_req = tbl[i].r1; p1_we = tbl[i].w1; p1_addr = tbl[i].a1; p1_wdata = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("row%0d_p0_gnt", i), {31'b0, p0_gnt}, {31'b0, tbl[i].g0});
      chk($sformatf("row%0d_p0_rvalid", i), {31'b0, p0_rvalid}, {31'b0, tbl[i].v0});
      chk($sformatf("row%0d_p0_rdata", i), {16'b0, p0_rdata}, {16'b0, tbl[i].rd0});
      chk($sformatf("row%0d_p1_gnt", i), {31'b0, p1_gnt}, {31'b0, tbl[i].g1});
      chk($sformatf("row%0d_p1_rvalid", i), {31'b0, p1_rvalid}, {31'b0, tbl[i].v1});
      chk($sformatf("row%0d_p1_rdata", i), {16'b0, p1_rdata}, {16'b0, tbl[i].rd1});
      chk($sformatf("row%0d_dmem_we", i), {31'b0, dmem_we}, {31'b0, tbl[i].we});
      chk($sformatf("row%0d_dmem_addr", i), {16'b0, dmem_addr}, {16'b0, tbl[i].da});
      chk($sformatf("row%0d_dmem_wdata", i), {16'b0, dmem_writedata}, {16'b0, tbl[i].dd});
      @(posedge clk); #1;
    end

    // Reset in the middle of a write access aborts it.
    p0_req = 1; p0_we = 1; p0_addr = 16'h0003; p0_wdata = 16'hDEAD;
    @(posedge clk); #1;
    chk("abort_pre_we", {31'b0, dmem_we}, 1);
    chk("abort_pre_gnt", {31'b0, p0_gnt}, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_we_drop", {31'b0, dmem_we}, 0);
    chk("abort_gnt_drop", {31'b0, p0_gnt}, 0);
    idle_inputs();
    @(posedge clk); #1;
    chk("abort_rvalid", {30'b0, p1_rvalid, p0_rvalid}, 0);
    chk("abort_dmem_we_hold", {31'b0, dmem_we}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    p0_req = 1; p0_we = 0; p0_addr = 16'h0003; p0_wdata = 16'h0000;
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(posedge clk); #1;
      if (p0_gnt) found = 1'b1;
    end
    chk("abort_read_gnt_seen", {31'b0, found}, 1);
    @(posedge clk); #1;
    p0_req = 0;
    chk("abort_read_rvalid", {31'b0, p0_rvalid}, 1);
    chk("abort_read_data", {16'b0, p0_rdata}, 32'h0000A503);
    @(posedge clk); #1;

`ifdef DMEM_ARB_LOCK_EN
    begin
      logic exp_order [4];
      logic got;
      exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 1;
      idle_inputs();
      do_reset();
      p0_req = 1; p0_we = 0; p0_addr = 16'h0004; p0_lock = 1;
      p1_req = 1; p1_we = 0; p1_addr = 16'h0005;
      for (int k = 0; k < 4; k++) begin
        found = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
          @(posedge clk); #1;
          if (p0_gnt || p1_gnt) begin
            found = 1'b1;
            got = p1_gnt;
          end
        end
        chk($sformatf("lock_gnt%0d_seen", k), {31'b0, found}, 1);
        chk($sformatf("lock_gnt%0d_port", k), {31'b0, got}, {31'b0, exp_order[k]});
        if (k == 2) begin
          @(posedge clk); #1;
          p0_lock = 0; p0_req = 0;
        end
      end
      @(posedge clk); #1;
      idle_inputs();
      @(posedge clk); #1;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single-port 16-bit data memory (dmem) between requesters.
- Port 0 is the CPU load/store unit; port 1 is the debug/program loader.
- Round-robin selection, registered command path, per-port response with valid pulse.
- Sits between the requesters and dmem; owns dmem's addr, write_enable and writedata.

Parameters:
- n, 16, data and address width in bits (matches dmem).
- r, 5, number of low address bits actually decoded by dmem; upper bits pass through unchanged.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous reset, active low.
- p0_req  input  1  port 0 request; held with p0_we/p0_addr/p0_wdata stable until p0_gnt.
- p0_we  input  1  port 0: 1 = write, 0 = read.
- p0_addr  input  n  port 0 address.
- p0_wdata  input  n  port 0 write data.
- p0_gnt  output  1  port 0 grant; one-cycle pulse.
- p0_rvalid  output  1  port 0 read data valid; one-cycle pulse.
- p0_rdata  output  n  port 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- dmem_addr  output  n  to dmem addr.
- dmem_we  output  1  to dmem write_enable.
- dmem_writedata  output  n  to dmem writedata.
- dmem_readdata  input  n  from dmem readdata; combinational read of dmem_addr.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, last=1 (port 0 wins the first tie).
  - dmem_we=0, dmem_addr=0, dmem_writedata=0.
  - All gnt/rvalid=0, p0_rdata=p1_rdata=0.
- FSM states IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: that port wins.
  - Both req: the port != last wins.
  - On the edge, capture winner index, we, addr and wdata into command registers; go to ACCESS.
- ACCESS (one cycle):
  - dmem_addr/dmem_writedata are driven from the command registers.
  - dmem_we = captured we.
  - gnt[winner]=1.
  - At the end edge: if read, rdata[winner] <= dmem_readdata.
  - last <= winner; go to DONE.
- DONE (one cycle):
  - rvalid[winner]=1 for reads only; writes give no rvalid.
  - dmem_we=0; go to IDLE.
- Latency: req seen in IDLE at cycle N -> gnt in N+1 -> rvalid and rdata valid in N+2.
- Throughput: one access per 3 cycles.
- Requester must drop req, or present a new command, in the cycle after gnt. A req still high in IDLE is a new request.
- rdata holds its value until that port's next read completes.
- dmem_we is high only in ACCESS and only for writes; never high in IDLE or DONE.
- dmem_addr/dmem_writedata hold their last values outside ACCESS.
- A req that changes while not yet granted is allowed; the values sampled on the IDLE edge win.
- Reset mid-ACCESS: the write is aborted (dmem_we falls asynchronously), no gnt/rvalid, FSM returns to IDLE.

Optional Feature:
- Macro DMEM_ARB_LOCK_EN.
- Defined:
  - Adds inputs p0_lock and p1_lock (1 bit).
  - If the winner's lock is high at its IDLE capture edge, set locked=1, owner=winner.
  - While locked, IDLE grants only owner and ignores the other port's req.
  - locked clears in any IDLE cycle where the owner's lock is low; arbitration resumes round-robin that same cycle.
  - Reset clears locked.
- Undefined: no lock ports and no locked state; pure round-robin.

Decomposition:
- Package dmem_arb_pkg: state enum typedef (IDLE, ACCESS, DONE), port index constants PORT0=0 and PORT1=1, default width constant 16.
- One sub-module, rr_pick2: combinational 2-way round-robin chooser.
  - Inputs: req[1:0], last.
  - Outputs: valid, winner.

Test Plan:
- Reset then p0 write addr 0x0000 data 0xFFFF -> dmem_we=1 exactly one cycle with dmem_addr=0x0000, dmem_writedata=0xFFFF; p0_gnt pulse; no p0_rvalid.
- p1 read addr 0x0000 after the above -> p1_gnt at N+1; p1_rvalid at N+2 with p1_rdata=0xFFFF; p0_rdata unchanged.
- p0 and p1 both request, p0 addr 0x0001 data 0x00FF, p1 addr 0x0002 data 0x0000, both writes:
  - p0 granted first (last=1 after reset), p1 granted 3 cycles later.
  - Repeat both -> p1 first, p0 second.
- Assert rst_n=0 mid-ACCESS of a write to 0x0003 -> dmem_we drops in the same timestep, no gnt; reading 0x0003 afterwards does not return the aborted data.
- p0 holds req high continuously while p1 requests once -> grants alternate p0, p1, p0; p1 is not starved.
- With DMEM_ARB_LOCK_EN: p0_lock=1 for 3 accesses while p1_req is held -> p0 granted 3 times, then p1 granted after p0_lock falls.
